// File: rtl/multi_fan_control_pkg.sv
// fan_ctrl_pkg: register map, mode/status encodings and clamp helper for the fan controller
package fan_ctrl_pkg;
    localparam logic [2:0] REG_PERIOD  = 3'd0;
    localparam logic [2:0] REG_DUTY    = 3'd1;
    localparam logic [2:0] REG_MODE    = 3'd2;
    localparam logic [2:0] REG_SENS    = 3'd3;
    localparam logic [2:0] REG_CURRENT = 3'd4;
    localparam logic [2:0] REG_TACH    = 3'd5;
    localparam logic [2:0] REG_RAMP    = 3'd6;
    localparam logic [2:0] REG_STATUS  = 3'd7;
    typedef enum logic {FAN_MANUAL = 1'b0, FAN_AUTO = 1'b1} fan_mode_e;
    localparam int STAT_STALL = 0;
    localparam int STAT_RAMP  = 1;
    function automatic logic signed [63:0] clamp(input logic signed [63:0] v, input logic signed [63:0] hi);
        return v < 64'sd0 ? 64'sd0 : (v > hi ? hi : v);
    endfunction
endpackage

// File: rtl/multi_fan_control_if.sv
// multi_fan_control_if: Avalon-MM port of the fan controller
interface multi_fan_control_if #(parameter int AW = 5);
    logic [AW-1:0] address;
    logic write;
    logic read;
    logic waitrequest;
    logic signed [31:0] writedata;
    logic signed [31:0] readdata;
    modport master (output address, write, writedata, read, input readdata, waitrequest);
    modport slave (input address, write, writedata, read, output readdata, waitrequest);
endinterface

// File: rtl/multi_fan_control_fan_channel.sv
// fan_channel: one PWM channel with shadowed period/duty, ramp limiter, auto target and tach counter
module fan_channel
    import fan_ctrl_pkg::*;
#(
    parameter int CLOCK_SPEED_HZ = 50_000_000,
    parameter int CNT_WIDTH = 24,
    parameter int DEFAULT_PERIOD = CLOCK_SPEED_HZ / 25_000
) (
    input  logic clk,
    input  logic reset,
    input  logic wr_en,
    input  logic [2:0] reg_sel,
    input  logic signed [31:0] wr_data,
    input  logic signed [31:0] current_average,
    input  logic tach,
    output logic pwm,
    output logic signed [31:0] rd_data
);
    localparam int GW = $clog2(CLOCK_SPEED_HZ);
    localparam logic [CNT_WIDTH-1:0] PERIOD_RST = CNT_WIDTH'(DEFAULT_PERIOD < 1 ? 1 : DEFAULT_PERIOD);
    logic [CNT_WIDTH-1:0] period, duty, ramp_step, cnt, period_act, duty_eff, target, next_duty, wr_cnt;
    logic signed [31:0] sens;
    fan_mode_e mode;
    logic signed [63:0] product;
    logic signed [CNT_WIDTH:0] diff;
    logic [CNT_WIDTH:0] mag;
    logic wrap, ramp_active, stall, rise, gate_end;
    logic [2:0] tach_sync;
    logic [GW-1:0] gate;
    logic [31:0] edge_cnt, edge_total, tach_count;
    assign wr_cnt = CNT_WIDTH'(wr_data);
    assign product = $signed(64'(current_average)) * $signed(64'(sens));
    assign target = mode == FAN_AUTO ? CNT_WIDTH'(clamp(product, $signed(64'(period_act)))) : duty;
    assign diff = $signed({1'b0, target}) - $signed({1'b0, duty_eff});
    assign mag = diff[CNT_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    assign next_duty = (ramp_step == '0 || mag <= {1'b0, ramp_step}) ? target :
                       diff[CNT_WIDTH] ? duty_eff - ramp_step : duty_eff + ramp_step;
    assign wrap = cnt == period_act - CNT_WIDTH'(1);
    assign ramp_active = ramp_step != '0 && duty_eff != target;
    // tach_sync[1:0] is the synchroniser, tach_sync[2] the previous sample for edge detect
    assign rise = tach_sync[1] & ~tach_sync[2];
    assign gate_end = gate == GW'(CLOCK_SPEED_HZ - 1);
    assign edge_total = edge_cnt + 32'(rise);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period <= PERIOD_RST;
            duty <= '0;
            mode <= FAN_MANUAL;
            sens <= 32'sd1;
            ramp_step <= '0;
        end else if (wr_en) begin
            case (reg_sel)
                REG_PERIOD: period <= wr_cnt == '0 ? CNT_WIDTH'(1) : wr_cnt;
                REG_DUTY:   duty <= wr_cnt;
                REG_MODE:   mode <= fan_mode_e'(wr_data[0]);
                REG_SENS:   sens <= wr_data;
                REG_RAMP:   ramp_step <= wr_cnt;
                default:    ;
            endcase
        end
    end
    // period_act and duty_eff only move at wrap so a period is never cut short
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            period_act <= PERIOD_RST;
            duty_eff <= '0;
            pwm <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + CNT_WIDTH'(1);
            if (wrap) begin
                period_act <= period;
                duty_eff <= next_duty;
            end
            pwm <= cnt < duty_eff;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tach_sync <= '0;
            gate <= '0;
            edge_cnt <= '0;
            tach_count <= '0;
            stall <= 1'b0;
        end else begin
            tach_sync <= {tach_sync[1:0], tach};
            gate <= gate_end ? '0 : gate + GW'(1);
            edge_cnt <= gate_end ? '0 : edge_total;
            if (gate_end) begin
                tach_count <= edge_total;
                stall <= edge_total == '0 && duty_eff != '0;
            end
        end
    end
    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_PERIOD:  rd_data = 32'(period);
            REG_DUTY:    rd_data = 32'(duty);
            REG_MODE:    rd_data = 32'(mode);
            REG_SENS:    rd_data = sens;
            REG_CURRENT: rd_data = current_average;
            REG_TACH:    rd_data = tach_count;
            REG_RAMP:    rd_data = 32'(ramp_step);
            default: begin
                rd_data[STAT_STALL] = stall;
                rd_data[STAT_RAMP] = ramp_active;
            end
        endcase
    end
endmodule

// File: rtl/multi_fan_control.sv
// multi_fan_control: Avalon-MM decode and readback for NUM_FANS independent PWM fan channels
module multi_fan_control
    import fan_ctrl_pkg::*;
#(
    parameter int NUM_FANS = 4,
    parameter int CLOCK_SPEED_HZ = 50_000_000,
    parameter int CNT_WIDTH = 24,
    parameter int DEFAULT_PERIOD = CLOCK_SPEED_HZ / 25_000
) (
    input  logic clk,
    input  logic reset,
    multi_fan_control_if.slave bus,
    input  logic signed [32*NUM_FANS-1:0] current_average,
    input  logic [NUM_FANS-1:0] tach,
    output logic [NUM_FANS-1:0] pwm
);
    localparam int AW = $clog2(NUM_FANS) + 3;
    logic [AW-1:0] ch;
    logic signed [31:0] rd_ch [NUM_FANS];
    logic signed [31:0] rd_sel;
    logic rd_done, rd_take;
    assign ch = bus.address >> 3;
    assign rd_take = bus.read && !rd_done;
    assign bus.waitrequest = rd_take;
    for (genvar i = 0; i < NUM_FANS; i++) begin : g_ch
        fan_channel #(
            .CLOCK_SPEED_HZ(CLOCK_SPEED_HZ),
            .CNT_WIDTH(CNT_WIDTH),
            .DEFAULT_PERIOD(DEFAULT_PERIOD)
        ) u_ch (
            .clk(clk),
            .reset(reset),
            .wr_en(bus.write && ch == AW'(i)),
            .reg_sel(bus.address[2:0]),
            .wr_data(bus.writedata),
            .current_average(current_average[32*i +: 32]),
            .tach(tach[i]),
            .pwm(pwm[i]),
            .rd_data(rd_ch[i])
        );
    end
    // unmatched channels fall through to zero
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NUM_FANS; k++) if (ch == AW'(k)) rd_sel = rd_ch[k];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_done <= 1'b0;
            bus.readdata <= '0;
        end else begin
            rd_done <= rd_take;
            if (rd_take) bus.readdata <= rd_sel;
        end
    end
endmodule

// File: tb/tb_multi_fan_control.sv
// tb_multi_fan_control: directed scoreboard bench for multi_fan_control with five channels
module tb_multi_fan_control;
    localparam int NF = 5;
    localparam int AW = $clog2(NF) + 3;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic signed [32*NF-1:0] cur = '0;
    logic tach3 = 1'b0;
    logic tach_en = 1'b0;
    logic [NF-1:0] tach;
    logic [NF-1:0] pwm;
    int n_assert = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    string tag_q[$];
    int pulses[$];
    int mon_ch = 1;
    int run = 0;
    int tcnt = 0;
    multi_fan_control_if #(.AW(AW)) bus();
    assign tach = {1'b0, tach3, 3'b000};
    multi_fan_control #(
        .NUM_FANS(NF),
        .CLOCK_SPEED_HZ(2400),
        .CNT_WIDTH(24),
        .DEFAULT_PERIOD(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .current_average(cur),
        .tach(tach),
        .pwm(pwm)
    );
    always #5 clk = ~clk;
    // high-pulse width monitor on the selected channel
    always @(negedge clk) begin
        if (pwm[mon_ch]) run++;
        else if (run > 0) begin
            pulses.push_back(run);
            run = 0;
        end
    end
    // 20-cycle tach period: exactly 120 rising edges in any 2400-cycle gate
    always @(negedge clk) begin
        if (tach_en) begin
            tcnt = tcnt == 9 ? 0 : tcnt + 1;
            if (tcnt == 0) tach3 = ~tach3;
        end
    end
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic expect_push(string tag, logic [31:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask
    task automatic check_pop(logic [31:0] obs);
        if (exp_q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
        else chk(tag_q.pop_front(), obs, exp_q.pop_front());
    endtask
    task automatic wr(int ch, int r, logic [31:0] data);
        @(negedge clk);
        bus.address = AW'(ch * 8 + r);
        bus.writedata = data;
        bus.write = 1'b1;
        @(negedge clk);
        bus.write = 1'b0;
    endtask
    task automatic rd(int ch, int r, logic [31:0] exp, logic [31:0] mask, string tag);
        int k = 0;
        @(negedge clk);
        bus.address = AW'(ch * 8 + r);
        bus.read = 1'b1;
        expect_push(tag, exp);
        #1;
        chk({tag, "_wait"}, 32'(bus.waitrequest), 32'd1);
        do begin
            @(negedge clk);
            k++;
        end while (bus.waitrequest && k < 8);
        check_pop(bus.readdata & mask);
        bus.read = 1'b0;
    endtask
    task automatic count_high(int ch, int n, string tag, logic [31:0] exp);
        int c = 0;
        expect_push(tag, exp);
        repeat (n) begin
            @(negedge clk);
            c += int'(pwm[ch]);
        end
        check_pop(32'(c));
    endtask
    task automatic wait_pwm(int ch, logic v, int budget, string tag);
        int k = 0;
        while (pwm[ch] !== v && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(pwm[ch]), 32'(v));
    endtask
    task automatic wait_pulses(int n, int budget, string tag);
        int k = 0;
        while (pulses.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(pulses.size() >= n), 32'd1);
    endtask
    initial begin
        int n0, c, others;
        bus.address = '0;
        bus.write = 1'b0;
        bus.read = 1'b0;
        bus.writedata = '0;
        repeat (3) @(negedge clk);
        chk("rst_pwm", 32'(pwm), 32'd0);
        chk("rst_readdata", bus.readdata, 32'd0);
        chk("rst_wait", 32'(bus.waitrequest), 32'd0);
        reset = 1'b0;
        rd(0, 0, 16, '1, "def_period");
        rd(1, 3, 1, '1, "def_sens");
        rd(2, 6, 0, '1, "def_ramp");
        rd(3, 2, 0, '1, "def_mode");
        // manual ch1: 25 of every 100 cycles, others idle
        wr(1, 0, 100);
        wr(1, 1, 25);
        repeat (250) @(negedge clk);
        c = 0;
        others = 0;
        expect_push("man_ch1_high", 25);
        expect_push("man_others_low", 0);
        repeat (100) begin
            @(negedge clk);
            c += int'(pwm[1]);
            others += int'(pwm[0] | pwm[2] | pwm[3] | pwm[4]);
        end
        check_pop(32'(c));
        check_pop(32'(others));
        // duty change mid-pulse applies from the next period only
        wait_pwm(1, 1'b0, 200, "mid_sync_low");
        wait_pwm(1, 1'b1, 200, "mid_sync_high");
        n0 = pulses.size();
        wr(1, 1, 75);
        wait_pulses(n0 + 2, 400, "mid_pulses_timeout");
        expect_push("mid_pulse_cur", 25);
        check_pop(32'(pulses[n0]));
        expect_push("mid_pulse_next", 75);
        check_pop(32'(pulses[n0 + 1]));
        // auto mode on ch0
        wr(0, 0, 100);
        wr(0, 3, 3);
        cur[31:0] = 10;
        wr(0, 2, 1);
        repeat (250) @(negedge clk);
        count_high(0, 100, "auto_10x3", 30);
        cur[31:0] = -5;
        repeat (250) @(negedge clk);
        count_high(0, 100, "auto_neg", 0);
        cur[31:0] = 1000;
        repeat (250) @(negedge clk);
        count_high(0, 100, "auto_clamp_high", 100);
        // ramp limiter on ch2
        wr(2, 0, 100);
        wr(2, 6, 10);
        repeat (20) @(negedge clk);
        mon_ch = 2;
        repeat (2) @(negedge clk);
        n0 = pulses.size();
        wr(2, 1, 45);
        wait_pulses(n0 + 1, 300, "ramp_first_timeout");
        rd(2, 7, 2, 32'd2, "ramp_active");
        wait_pulses(n0 + 6, 800, "ramp_timeout");
        for (int i = 0; i < 6; i++) begin
            expect_push($sformatf("ramp_step%0d", i), i < 4 ? 32'(10 * (i + 1)) : 32'd45);
            check_pop(32'(pulses[n0 + i]));
        end
        rd(2, 7, 0, 32'd2, "ramp_done");
        // tach on ch3, stall on ch4
        wr(3, 1, 50);
        wr(4, 1, 50);
        tach_en = 1'b1;
        repeat (5000) @(negedge clk);
        rd(3, 5, 120, '1, "tach_120");
        rd(3, 7, 0, 32'd1, "tach_no_stall");
        rd(4, 5, 0, '1, "tach_zero");
        rd(4, 7, 1, 32'd1, "stall");
        // bus boundaries
        rd(5, 0, 0, '1, "oob_read");
        wr(5, 0, 77);
        rd(1, 0, 100, '1, "oob_write_no_alias");
        wr(0, 4, 55);
        rd(0, 4, 1000, '1, "ro_write_ignored");
        @(negedge clk);
        bus.address = AW'(3);
        bus.read = 1'b1;
        bus.write = 1'b1;
        bus.writedata = 7;
        expect_push("rw_same_old", 3);
        @(negedge clk);
        bus.write = 1'b0;
        chk("rw_same_wait", 32'(bus.waitrequest), 32'd0);
        check_pop(bus.readdata);
        bus.read = 1'b0;
        rd(0, 3, 7, '1, "rw_same_new");
        wr(0, 0, 0);
        rd(0, 0, 1, '1, "period_zero");
        // reset in the middle of a high output
        repeat (150) @(negedge clk);
        wait_pwm(0, 1'b1, 300, "pre_reset_high");
        #2 reset = 1'b1;
        #1;
        chk("reset_async_pwm", 32'(pwm), 32'd0);
        chk("reset_async_readdata", bus.readdata, 32'd0);
        chk("reset_async_wait", 32'(bus.waitrequest), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cur = '0;
        tach_en = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_reset_pwm", 32'(pwm), 32'd0);
        rd(0, 0, 16, '1, "post_reset_period");
        rd(0, 3, 1, '1, "post_reset_sens");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
